gtfmac_vnc_stat_snap_ctrl: RTL and testbench

Sequences snapshot and readout of a bank of 64-bit statistic collectors in one MAC clock domain. It issues the snapshot tick, waits for the collectors to latch, then walks the shared stat read mux index by index. Each value is copied into a shadow array that software reads coherently. It sits between the register/AXI-lite front end and the per-port packet statistic blocks.

---
 rtl/gtfmac_vnc_stat_snap_ctrl_pkg.sv | 17 +
 rtl/gtfmac_vnc_stat_snap_ctrl_if.sv | 28 ++
 rtl/gtfmac_vnc_stat_snap_ctrl_interval_timer.sv | 27 ++
 rtl/gtfmac_vnc_stat_snap_ctrl.sv | 140 ++++++++++++++
 tb/tb_gtfmac_vnc_stat_snap_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gtfmac_vnc_stat_snap_ctrl_pkg.sv
// Shared types for the statistics snapshot controller: FSM states, stat word, saturation limit.
package gtfmac_vnc_stat_pkg;

    typedef logic [63:0] stat_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TICK    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SEL     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/gtfmac_vnc_stat_snap_ctrl_if.sv
// Controller bus: software request/readout side plus the collector tick/read-mux side.
interface gtfmac_vnc_stat_snap_ctrl_if #(
    parameter int IDX_W = 6
);
    import gtfmac_vnc_stat_pkg::*;

    logic             snap_req;
    logic [31:0]      interval;
    logic             stat_tick;
    logic [IDX_W-1:0] stat_sel;
    stat_t            stat_data;
    logic [IDX_W-1:0] rd_idx;
    stat_t            rd_data;
    logic             busy;
    logic             snap_done;
    logic [31:0]      snap_count;
    logic [15:0]      overrun_count;

    modport master (
        output snap_req, interval, stat_data, rd_idx,
        input  stat_tick, stat_sel, rd_data, busy, snap_done, snap_count, overrun_count
    );

    modport slave (
        input  snap_req, interval, stat_data, rd_idx,
        output stat_tick, stat_sel, rd_data, busy, snap_done, snap_count, overrun_count
    );
endinterface

// File: rtl/gtfmac_vnc_stat_snap_ctrl_interval_timer.sv
// Auto-tick counter: raises expire_o for one cycle every interval_i cycles; interval_i=0 holds it cleared.
module gtfmac_vnc_stat_interval_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] interval_i,
    output logic        expire_o
);
    logic [31:0] timer_q, timer_d;

    // A shrunk interval below the current count wraps through 2**32 before matching.
    assign expire_o = (interval_i != 32'd0) && (timer_q == interval_i - 32'd1);

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (interval_i == 32'd0 || expire_o) begin
            timer_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
endmodule

// File: rtl/gtfmac_vnc_stat_snap_ctrl.sv
// Snapshot tick + shadow walk over the shared stat read mux.
// Define STAT_AUTO_TICK_EN to add the interval-driven auto-tick timer.
module gtfmac_vnc_stat_snap_ctrl
    import gtfmac_vnc_stat_pkg::*;
#(
    parameter int NUM_STATS  = 8,
    parameter int SETTLE_CYC = 4,
    parameter int RD_LAT     = 2,
    parameter int IDX_W      = 6
) (
    input logic                         clk,
    input logic                         rst,
    gtfmac_vnc_stat_snap_ctrl_if.slave  ctrl_io
);
    localparam int               SH_W      = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
    localparam int               SH_DEPTH  = 1 << SH_W;
    localparam logic [15:0]      SETTLE_LD = 16'(SETTLE_CYC - 1);
    localparam logic [15:0]      RD_LD     = 16'(RD_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STATS - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [31:0]      snap_q, snap_d;
    logic [15:0]      ovr_q, ovr_d;
    stat_t            rd_data_q;
    stat_t            shadow_mem [SH_DEPTH];
    logic             req;

`ifdef STAT_AUTO_TICK_EN
    logic tmr_expire;

    gtfmac_vnc_stat_interval_timer u_interval_timer (
        .clk        (clk),
        .rst        (rst),
        .interval_i (ctrl_io.interval),
        .expire_o   (tmr_expire)
    );

    assign req = ctrl_io.snap_req | tmr_expire;
`else
    assign req = ctrl_io.snap_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        snap_d  = snap_q;
        ovr_d   = ovr_q;
        // One request can wait behind a running walk; further ones are dropped and counted.
        if (state_q != ST_IDLE && req) begin
            if (!pend_q) begin
                pend_d = 1'b1;
            end else if (ovr_q != OVERRUN_MAX) begin
                ovr_d = ovr_q + 16'd1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    state_d = ST_TICK;
                    pend_d  = 1'b0;
                end
            end
            ST_TICK: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                    cnt_d   = RD_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_SEL: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_CAPTURE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SEL;
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = RD_LD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                snap_d  = snap_q + 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            snap_q    <= 32'd0;
            ovr_q     <= 16'd0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            snap_q    <= snap_d;
            ovr_q     <= ovr_d;
            rd_data_q <= shadow_mem[ctrl_io.rd_idx[SH_W-1:0]];
        end
    end

    // No reset on the shadow so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (state_q == ST_CAPTURE) begin
            shadow_mem[idx_q[SH_W-1:0]] <= ctrl_io.stat_data;
        end
    end

    assign ctrl_io.stat_tick     = (state_q == ST_TICK);
    assign ctrl_io.snap_done     = (state_q == ST_DONE);
    assign ctrl_io.busy          = (state_q == ST_TICK) || (state_q == ST_SETTLE) ||
                                   (state_q == ST_SEL)  || (state_q == ST_CAPTURE);
    assign ctrl_io.stat_sel      = idx_q;
    assign ctrl_io.rd_data       = rd_data_q;
    assign ctrl_io.snap_count    = snap_q;
    assign ctrl_io.overrun_count = ovr_q;
endmodule

// File: tb/tb_gtfmac_vnc_stat_snap_ctrl.sv
// Scoreboard bench for the snapshot controller: request-window reference model, queued tick/done events.
module tb_gtfmac_vnc_stat_snap_ctrl;
    import gtfmac_vnc_stat_pkg::*;

    localparam int NUM_STATS  = 8;
    localparam int SETTLE_CYC = 4;
    localparam int RD_LAT     = 2;
    localparam int IDX_W      = 6;
    localparam int WALK       = 2 + SETTLE_CYC + NUM_STATS * (RD_LAT + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gtfmac_vnc_stat_snap_ctrl_if #(.IDX_W(IDX_W)) sif ();

    gtfmac_vnc_stat_snap_ctrl #(
        .NUM_STATS  (NUM_STATS),
        .SETTLE_CYC (SETTLE_CYC),
        .RD_LAT     (RD_LAT),
        .IDX_W      (IDX_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (sif)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Collector bank: latches a generation number at each tick; mux has RD_LAT cycles of delay.
    logic [31:0] tick_cnt = 32'd0;
    logic [31:0] lgen     = 32'd0;
    stat_t       pipe [RD_LAT];

    function automatic stat_t coll_val(input logic [IDX_W-1:0] i, input logic [31:0] g);
        logic [15:0] lo;
        lo = 16'h1000 + 16'(i);
        return {g, 16'h0000, lo};
    endfunction

    always @(posedge clk) begin
        if (sif.stat_tick) begin
            lgen     <= tick_cnt;
            tick_cnt <= tick_cnt + 32'd1;
        end
        pipe[0] <= coll_val(sif.stat_sel, lgen);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sif.stat_data = pipe[RD_LAT-1];

    // Reference model: time windows of each walk, one pending slot, counters.
    int tick_q[$];
    int done_q[$];
    int m_start = -1000, m_end = -1000, m_last_rst = -1000;
    int m_pend = 0, m_snaps = 0, m_ovr = 0, m_starts = 0, m_walk_gen = 0, m_valid = 0;
    int m_int_start = 0, cur_interval = 0, next_interval = 0;
    logic [IDX_W-1:0] rd_sel = '0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic model_cycle(input int k, input bit r_sw, input bit r_rst);
        bit req;
        if (r_rst) begin
            while (tick_q.size() > 0 && tick_q[$] > k) void'(tick_q.pop_back());
            while (done_q.size() > 0 && done_q[$] > k) void'(done_q.pop_back());
            if (k > m_start && k <= m_end) m_valid = 0;
            if (m_end > k) m_end = k;
            m_pend = 0; m_snaps = 0; m_ovr = 0;
            m_int_start = k + 1;
            m_last_rst = k;
            return;
        end
        req = r_sw;
`ifdef STAT_AUTO_TICK_EN
        if (cur_interval != 0 && ((k - m_int_start) % cur_interval) == cur_interval - 1) req = 1'b1;
`endif
        if (k > m_end) begin
            if (req || m_pend != 0) begin
                m_start = k;
                m_end   = k + WALK;
                tick_q.push_back(k + 1);
                done_q.push_back(k + WALK);
                m_walk_gen = m_starts;
                m_starts++;
                m_snaps++;
                m_valid = 1;
                m_pend  = 0;
            end
        end else if (req) begin
            if (m_pend == 0) m_pend = 1;
            else             m_ovr++;
        end
    endtask

    task automatic step(input bit r, input bit rs);
        @(posedge clk);
        #1;
        sif.snap_req = r;
        rst = rs;
        if (cur_interval == 0 && next_interval != 0) m_int_start = cyc;
        cur_interval = next_interval;
        sif.interval = 32'(next_interval);
        sif.rd_idx = rd_sel;
        model_cycle(cyc, r, rs);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cyc <= m_end + 2) begin
            step(1'b0, 1'b0);
            n++;
            if (n > 500) begin
                fail("wait_idle timeout");
                break;
            end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, " snap_count"}, 64'(sif.snap_count), 64'(m_snaps));
        chk({tag, " overrun_count"}, 64'(sif.overrun_count), 64'(m_ovr));
    endtask

    // Monitor: pops expected tick/done events, checks busy and shadow reads every cycle.
    logic [IDX_W-1:0] rd_prev = '0;
    bit               have_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            while (tick_q.size() > 0 && tick_q[0] < cyc) begin
                fail($sformatf("stat_tick missing, expected at cycle %0d", tick_q[0]));
                void'(tick_q.pop_front());
            end
            if (sif.stat_tick === 1'b1) begin
                if (tick_q.size() == 0) fail("stat_tick unexpected, expected none");
                else chk("stat_tick cycle", 64'(cyc), 64'(tick_q.pop_front()));
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                fail($sformatf("snap_done missing, expected at cycle %0d", done_q[0]));
                void'(done_q.pop_front());
            end
            if (sif.snap_done === 1'b1) begin
                if (done_q.size() == 0) fail("snap_done unexpected, expected none");
                else chk("snap_done cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
            chk("busy", 64'(sif.busy),
                64'((cyc > m_start && cyc < m_start + WALK && cyc <= m_end) ? 1 : 0));
            if (have_prev && m_valid != 0 && cyc - 2 > m_end && m_last_rst != cyc - 1)
                chk("rd_data", sif.rd_data, coll_val(rd_prev, 32'(m_walk_gen)));
            rd_prev   = sif.rd_idx;
            have_prev = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        sif.snap_req = 1'b0;
        sif.interval = 32'd0;
        sif.rd_idx   = '0;
        repeat (3) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("reset stat_tick", 64'(sif.stat_tick), 64'd0);
        chk("reset busy", 64'(sif.busy), 64'd0);
        chk("reset snap_done", 64'(sif.snap_done), 64'd0);
        chk("reset stat_sel", 64'(sif.stat_sel), 64'd0);
        chk("reset rd_data", sif.rd_data, 64'd0);
        chk("reset snap_count", 64'(sif.snap_count), 64'd0);
        chk("reset overrun_count", 64'(sif.overrun_count), 64'd0);
        mon_en = 1'b1;

        // Basic walk
        step(1'b1, 1'b0);
        wait_idle();
        rd_sel = 5;
        repeat (3) step(1'b0, 1'b0);
        chk("basic rd_data[5]", sif.rd_data, 64'h1005);
        chk("basic snap_count", 64'(sif.snap_count), 64'd1);
        check_counts("basic");

        // Pending request
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        wait_idle();
        check_counts("pending");

        // Overrun: three requests inside one walk window
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        wait_idle();
        check_counts("overrun");

        // Reset mid-walk at idx 3
        step(1'b1, 1'b0);
        n = 0;
        while (!(sif.busy && sif.stat_sel == 3) && n < 100) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 100) fail("reset test never reached idx 3");
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("post-reset busy", 64'(sif.busy), 64'd0);
        chk("post-reset stat_tick", 64'(sif.stat_tick), 64'd0);
        step(1'b1, 1'b0);
        wait_idle();
        check_counts("after reset");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rd_sel = IDX_W'($urandom_range(0, NUM_STATS - 1));
            step(($urandom % 20) == 0, ($urandom % 600) == 0);
        end
        wait_idle();
        check_counts("random");

`ifdef STAT_AUTO_TICK_EN
        next_interval = 100;
        repeat (350) step(1'b0, 1'b0);
        next_interval = 0;
        repeat (300) step(1'b0, 1'b0);
        wait_idle();
        check_counts("auto tick");
        next_interval = 50;
        step(1'b0, 1'b0);
        repeat (48) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        next_interval = 0;
        step(1'b0, 1'b0);
        wait_idle();
        check_counts("simultaneous");
`else
        next_interval = 7;
        repeat (200) step(1'b0, 1'b0);
        next_interval = 0;
        wait_idle();
        check_counts("interval ignored");
`endif

        repeat (3) step(1'b0, 1'b0);
        chk("tick queue drained", 64'(tick_q.size()), 64'd0);
        chk("done queue drained", 64'(done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
